systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Upstream-side driver for the 2x2 systolic array. It is the block that produces every array input: weight-load beats with accept_w, the switch pulse, the row-skewed input stream and the start/valid pulses.
- It accepts weights and input vectors from the host/buffer side over valid/ready handshakes. It sequences one job: load weights, switch, stream inputs, drain. It then raises done.

Parameters:
- DATA_WIDTH, 16, width of every weight/data word.
- DRAIN_CYCLES, 3, cycles after the last input beat before done (covers array pipeline depth).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- w_valid  in  1  weight beat valid.
- w_ready  out  1  feeder can accept a weight beat.
- w_row_0  in  DATA_WIDTH  weight for column 1 PEs (pe11/pe21 path).
- w_row_1  in  DATA_WIDTH  weight for column 2 PEs (pe12/pe22 path).
- x_valid  in  1  input vector valid.
- x_ready  out  1  feeder can accept an input vector.
- x_col_0  in  DATA_WIDTH  element for array row 1.
- x_col_1  in  DATA_WIDTH  element for array row 2.
- x_last  in  1  marks the final input vector of the job.
- busy  out  1  a job is in progress.
- done  out  1  one-cycle pulse at job end.
- sys_start  out  1  valid into top-left PE, one per input vector.
- sys_switch_in  out  1  shadow-to-active weight switch pulse.
- sys_accept_w_in  out  1  weight shift enable.
- sys_weight_in_11  out  DATA_WIDTH  top-row weight, column 1.
- sys_weight_in_12  out  DATA_WIDTH  top-row weight, column 2.
- sys_data_in_11  out  DATA_WIDTH  row-1 input.
- sys_data_in_12  out  DATA_WIDTH  row-2 input, skewed by one cycle.

Behaviour:
- All array-side outputs are registered.
- Reset (rst==0 at a clk edge) drives these to 0: all outputs, busy, done, the skew register and the drain counter. State goes to W0.
- Reset mid-job aborts with no done pulse. Any partially shifted weights are simply overwritten by the next job.
- State W0:
  - w_ready=1, x_ready=0.
  - On w_valid&w_ready, the next cycle shows sys_weight_in_11/12 = w_row_0/1 with sys_accept_w_in=1; state goes to W1 and busy goes to 1.
  - The first beat is the bottom-row (pe21/pe22) weights.
- State W1:
  - w_ready=1.
  - On accept, the next cycle presents the top-row weights with accept_w=1; state goes to SWITCH.
  - If no w_valid arrives, the weight outputs go to 0 and accept_w=0. The first beat stays latched in the top-row shadow registers, so the gap is harmless.
- State SWITCH:
  - Exactly one cycle.
  - The next cycle shows sys_switch_in=1, accept_w=0 and weight outputs 0; state goes to STREAM.
  - switch precedes the first sys_start by at least 1 cycle.
- State STREAM:
  - x_ready=1 unconditionally; the array cannot stall.
  - On x_valid, the next cycle shows sys_data_in_11=x_col_0 and sys_start=1. x_col_1 is captured in the skew register and appears on sys_data_in_12 one cycle after that.
  - On a cycle without x_valid: sys_start=0, sys_data_in_11=0. sys_data_in_12 still emits the skew register, which holds 0 after a bubble.
  - On an accepted beat with x_last=1, state goes to DRAIN and x_ready drops the next cycle.
- State DRAIN:
  - x_ready=0, w_ready=0.
  - The first DRAIN cycle flushes the skew register onto sys_data_in_12; afterwards data outputs are 0.
  - The counter runs DRAIN_CYCLES cycles. On the final cycle done=1 for one cycle, busy drops with it, and state returns to W0.
- Back-to-back jobs:
  - A w_valid presented in the done cycle is not accepted, because w_ready is 0 in DRAIN.
  - It is accepted in the following cycle.
- Ordering guarantees:
  - x_valid during W0/W1/SWITCH is ignored (x_ready=0).
  - w_valid during STREAM/DRAIN is ignored.
- Widths: data is passed through unmodified; no arithmetic is performed.

Test Plan:
- Weight load: after reset, send beats (1,2) then (3,4) back-to-back.
  - Cycle+1: weights 1/2, accept_w=1.
  - Cycle+2: weights 3/4, accept_w=1.
  - Cycle+3: switch=1, accept_w=0, weights 0.
  - Then x_ready=1.
- Skewed stream: vectors (5,6), (7,8, last) on consecutive cycles.
  - sys_data_in_11 = 5, 7, 0.
  - sys_data_in_12 = 0, 6, 8.
  - sys_start = 1, 1, 0.
  - done exactly DRAIN_CYCLES=3 cycles after the last accept, then w_ready=1.
- Bubble: vectors (1,1), gap, (2,2, last).
  - sys_start = 1, 0, 1.
  - sys_data_in_12 = 0, 1, 0, 2.
  - No spurious start during the gap.
- Weight gap: w_valid deasserted for 3 cycles between the two beats.
  - accept_w low during the gap.
  - Switch follows the second beat by 1 cycle.
  - Stays in W1 until the second beat.
- Reset mid-STREAM: drive rst=0 for 1 cycle.
  - All outputs are 0 the next cycle; no done pulse.
  - w_ready=1 after release.
- Illegal-order stimulus:
  - x_valid held high during W0 produces no start.
  - w_valid during STREAM leaves accept_w=0 throughout.

Source files
------------

// File: rtl/systolic_feeder.sv
// Upstream sequencer for the 2x2 systolic array: loads two weight rows, pulses switch,
// streams row-skewed input vectors, drains the array pipeline and pulses done.
module systolic_feeder #(
  parameter int DATA_WIDTH   = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] w_row_0,
  input  logic [DATA_WIDTH-1:0] w_row_1,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_col_0,
  input  logic [DATA_WIDTH-1:0] x_col_1,
  input  logic                  x_last,
  output logic                  busy,
  output logic                  done,
  output logic                  sys_start,
  output logic                  sys_switch_in,
  output logic                  sys_accept_w_in,
  output logic [DATA_WIDTH-1:0] sys_weight_in_11,
  output logic [DATA_WIDTH-1:0] sys_weight_in_12,
  output logic [DATA_WIDTH-1:0] sys_data_in_11,
  output logic [DATA_WIDTH-1:0] sys_data_in_12
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {W0, W1, SWITCH, STREAM, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  w_ready_q, w_ready_d;
  logic                  x_ready_q, x_ready_d;
  logic                  start_q, start_d;
  logic                  switch_q, switch_d;
  logic                  accept_q, accept_d;
  logic [DATA_WIDTH-1:0] w11_q, w11_d;
  logic [DATA_WIDTH-1:0] w12_q, w12_d;
  logic [DATA_WIDTH-1:0] d11_q, d11_d;
  logic [DATA_WIDTH-1:0] d12_q, d12_d;
  logic [DATA_WIDTH-1:0] skew_q, skew_d;
  logic                  w_fire, x_fire;

  always_comb begin
    w_fire   = w_valid & w_ready_q;
    x_fire   = x_valid & x_ready_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    start_d  = 1'b0;
    switch_d = 1'b0;
    accept_d = 1'b0;
    w11_d    = '0;
    w12_d    = '0;
    d11_d    = '0;
    skew_d   = '0;
    d12_d    = skew_q;
    case (state_q)
      W0: if (w_fire) begin
        accept_d = 1'b1;
        w11_d    = w_row_0;
        w12_d    = w_row_1;
        busy_d   = 1'b1;
        state_d  = W1;
      end
      W1: if (w_fire) begin
        accept_d = 1'b1;
        w11_d    = w_row_0;
        w12_d    = w_row_1;
        state_d  = SWITCH;
      end
      SWITCH: begin
        switch_d = 1'b1;
        state_d  = STREAM;
      end
      STREAM: if (x_fire) begin
        start_d = 1'b1;
        d11_d   = x_col_0;
        skew_d  = x_col_1;
        if (x_last) begin
          cnt_d   = CW'(DRAIN_CYCLES - 1);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = W0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = W0;
    endcase
    // Hold w_ready low through the done cycle so a new job starts the cycle after.
    w_ready_d = ((state_d == W0) || (state_d == W1)) && !done_d;
    x_ready_d = (state_d == STREAM);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= W0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_ready_q <= 1'b0;
      x_ready_q <= 1'b0;
      start_q   <= 1'b0;
      switch_q  <= 1'b0;
      accept_q  <= 1'b0;
      w11_q     <= '0;
      w12_q     <= '0;
      d11_q     <= '0;
      d12_q     <= '0;
      skew_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_ready_q <= w_ready_d;
      x_ready_q <= x_ready_d;
      start_q   <= start_d;
      switch_q  <= switch_d;
      accept_q  <= accept_d;
      w11_q     <= w11_d;
      w12_q     <= w12_d;
      d11_q     <= d11_d;
      d12_q     <= d12_d;
      skew_q    <= skew_d;
    end
  end

  assign w_ready          = w_ready_q;
  assign x_ready          = x_ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign sys_start        = start_q;
  assign sys_switch_in    = switch_q;
  assign sys_accept_w_in  = accept_q;
  assign sys_weight_in_11 = w11_q;
  assign sys_weight_in_12 = w12_q;
  assign sys_data_in_11   = d11_q;
  assign sys_data_in_12   = d12_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: weight load, skewed streaming, bubbles,
// weight gaps, back-to-back jobs, mid-job reset and out-of-order handshakes.
module tb_systolic_feeder;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_valid, w_ready, x_valid, x_ready, x_last;
  logic [DW-1:0] w_row_0, w_row_1, x_col_0, x_col_1;
  logic          busy, done, sys_start, sys_switch_in, sys_accept_w_in;
  logic [DW-1:0] sys_weight_in_11, sys_weight_in_12, sys_data_in_11, sys_data_in_12;

  int checks = 0;
  int errors = 0;

  systolic_feeder #(.DATA_WIDTH(DW), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_row_0(w_row_0), .w_row_1(w_row_1),
    .x_valid(x_valid), .x_ready(x_ready), .x_col_0(x_col_0), .x_col_1(x_col_1),
    .x_last(x_last), .busy(busy), .done(done),
    .sys_start(sys_start), .sys_switch_in(sys_switch_in), .sys_accept_w_in(sys_accept_w_in),
    .sys_weight_in_11(sys_weight_in_11), .sys_weight_in_12(sys_weight_in_12),
    .sys_data_in_11(sys_data_in_11), .sys_data_in_12(sys_data_in_12)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_w(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
    w_valid = v; w_row_0 = a; w_row_1 = b;
  endtask

  task automatic drive_x(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic l);
    x_valid = v; x_col_0 = a; x_col_1 = b; x_last = l;
  endtask

  task automatic load_weights(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] c, input logic [DW-1:0] d);
    drive_w(1'b1, a, b); tick();
    drive_w(1'b1, c, d); tick();
    drive_w(1'b0, '0, '0); tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_w(1'b0, '0, '0);
    drive_x(1'b0, '0, '0, 1'b0);
    tick(); tick();
    checks++;
    if ({busy, done, sys_start, sys_switch_in, sys_accept_w_in, x_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
        {busy, done, sys_start, sys_switch_in, sys_accept_w_in, x_ready});
    end
    checks++;
    if ({sys_weight_in_11, sys_weight_in_12, sys_data_in_11, sys_data_in_12} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want 0", sys_weight_in_11,
        sys_weight_in_12, sys_data_in_11, sys_data_in_12);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (w_ready !== 1'b1) begin errors++; $display("FAIL reset_w_ready got %b want 1", w_ready); end
  endtask

  task automatic test_weight_load();
    drive_w(1'b1, 16'd1, 16'd2); tick();
    checks++;
    if ({sys_accept_w_in, busy, sys_weight_in_11, sys_weight_in_12} !== {2'b11, 16'd1, 16'd2}) begin
      errors++; $display("FAIL wload_beat0 got acc=%b busy=%b w=%0d/%0d want 1 1 1/2",
        sys_accept_w_in, busy, sys_weight_in_11, sys_weight_in_12);
    end
    drive_w(1'b1, 16'd3, 16'd4); tick();
    checks++;
    if ({sys_accept_w_in, sys_switch_in, sys_weight_in_11, sys_weight_in_12} !== {2'b10, 16'd3, 16'd4}) begin
      errors++; $display("FAIL wload_beat1 got acc=%b sw=%b w=%0d/%0d want 1 0 3/4",
        sys_accept_w_in, sys_switch_in, sys_weight_in_11, sys_weight_in_12);
    end
    drive_w(1'b0, '0, '0); tick();
    checks++;
    if ({sys_switch_in, sys_accept_w_in, sys_weight_in_11, sys_weight_in_12, x_ready, w_ready}
        !== {2'b10, 32'd0, 2'b10}) begin
      errors++; $display("FAIL wload_switch got sw=%b acc=%b w=%0d/%0d xr=%b wr=%b want 1 0 0/0 1 0",
        sys_switch_in, sys_accept_w_in, sys_weight_in_11, sys_weight_in_12, x_ready, w_ready);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] e11 [3] = '{16'd5, 16'd7, 16'd0};
    logic [DW-1:0] e12 [3] = '{16'd0, 16'd6, 16'd8};
    logic          est [3] = '{1'b1, 1'b1, 1'b0};
    for (int unsigned i = 0; i < 3; i++) begin
      case (i)
        0: drive_x(1'b1, 16'd5, 16'd6, 1'b0);
        1: drive_x(1'b1, 16'd7, 16'd8, 1'b1);
        default: drive_x(1'b0, '0, '0, 1'b0);
      endcase
      tick();
      checks++;
      if ({sys_data_in_11, sys_data_in_12, sys_start} !== {e11[i], e12[i], est[i]}) begin
        errors++; $display("FAIL stream_%0d got d11=%0d d12=%0d st=%b want %0d %0d %b",
          i, sys_data_in_11, sys_data_in_12, sys_start, e11[i], e12[i], est[i]);
      end
    end
    checks++;
    if (x_ready !== 1'b0) begin errors++; $display("FAIL stream_x_ready_drop got %b want 0", x_ready); end
    tick();
    checks++;
    if ({done, sys_data_in_12, busy} !== {1'b0, 16'd0, 1'b1}) begin
      errors++; $display("FAIL drain_mid got done=%b d12=%0d busy=%b want 0 0 1",
        done, sys_data_in_12, busy);
    end
    tick();
    checks++;
    if ({done, busy, w_ready} !== 3'b100) begin
      errors++; $display("FAIL drain_done got done=%b busy=%b wr=%b want 1 0 0", done, busy, w_ready);
    end
    tick();
    checks++;
    if ({done, w_ready} !== 2'b01) begin
      errors++; $display("FAIL drain_after got done=%b wr=%b want 0 1", done, w_ready);
    end
  endtask

  task automatic test_bubble();
    logic          est [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [DW-1:0] e12 [4] = '{16'd0, 16'd1, 16'd0, 16'd2};
    load_weights(16'd1, 16'd1, 16'd1, 16'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      case (i)
        0: drive_x(1'b1, 16'd1, 16'd1, 1'b0);
        2: drive_x(1'b1, 16'd2, 16'd2, 1'b1);
        default: drive_x(1'b0, '0, '0, 1'b0);
      endcase
      tick();
      checks++;
      if ({sys_start, sys_data_in_12} !== {est[i], e12[i]}) begin
        errors++; $display("FAIL bubble_%0d got st=%b d12=%0d want %b %0d",
          i, sys_start, sys_data_in_12, est[i], e12[i]);
      end
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL bubble_done got %b want 1", done); end
  endtask

  task automatic test_back_to_back();
    drive_w(1'b1, 16'd9, 16'd10); tick();
    checks++;
    if ({sys_accept_w_in, done, w_ready} !== 3'b001) begin
      errors++; $display("FAIL b2b_done_cycle got acc=%b done=%b wr=%b want 0 0 1",
        sys_accept_w_in, done, w_ready);
    end
    tick();
    checks++;
    if ({sys_accept_w_in, busy, sys_weight_in_11, sys_weight_in_12} !== {2'b11, 16'd9, 16'd10}) begin
      errors++; $display("FAIL b2b_accept got acc=%b busy=%b w=%0d/%0d want 1 1 9/10",
        sys_accept_w_in, busy, sys_weight_in_11, sys_weight_in_12);
    end
  endtask

  task automatic test_weight_gap();
    drive_w(1'b0, 16'hdead, 16'hbeef);
    drive_x(1'b1, 16'd77, 16'd78, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({sys_accept_w_in, sys_switch_in, sys_start, w_ready, sys_weight_in_11, sys_weight_in_12}
          !== {4'b0001, 32'd0}) begin
        errors++; $display("FAIL wgap_%0d got acc=%b sw=%b st=%b wr=%b w=%0d/%0d want 0 0 0 1 0/0",
          i, sys_accept_w_in, sys_switch_in, sys_start, w_ready, sys_weight_in_11, sys_weight_in_12);
      end
    end
    drive_w(1'b1, 16'd11, 16'd12); tick();
    checks++;
    if ({sys_accept_w_in, sys_weight_in_11, sys_weight_in_12, sys_start} !== {1'b1, 16'd11, 16'd12, 1'b0}) begin
      errors++; $display("FAIL wgap_beat1 got acc=%b w=%0d/%0d st=%b want 1 11/12 0",
        sys_accept_w_in, sys_weight_in_11, sys_weight_in_12, sys_start);
    end
    drive_w(1'b0, '0, '0); tick();
    checks++;
    if ({sys_switch_in, sys_start, sys_accept_w_in} !== 3'b100) begin
      errors++; $display("FAIL wgap_switch got sw=%b st=%b acc=%b want 1 0 0",
        sys_switch_in, sys_start, sys_accept_w_in);
    end
  endtask

  task automatic test_reset_mid_stream();
    drive_w(1'b1, 16'd55, 16'd66);
    drive_x(1'b1, 16'd3, 16'd4, 1'b0); tick();
    checks++;
    if ({sys_start, sys_data_in_11, sys_accept_w_in} !== {1'b1, 16'd3, 1'b0}) begin
      errors++; $display("FAIL illegal_w_stream0 got st=%b d11=%0d acc=%b want 1 3 0",
        sys_start, sys_data_in_11, sys_accept_w_in);
    end
    drive_x(1'b1, 16'd5, 16'd6, 1'b0); tick();
    checks++;
    if ({sys_accept_w_in, sys_data_in_12} !== {1'b0, 16'd4}) begin
      errors++; $display("FAIL illegal_w_stream1 got acc=%b d12=%0d want 0 4",
        sys_accept_w_in, sys_data_in_12);
    end
    rst = 1'b0; tick();
    checks++;
    if ({busy, done, sys_start, sys_switch_in, sys_accept_w_in, x_ready, sys_data_in_11,
         sys_data_in_12, sys_weight_in_11, sys_weight_in_12} !== '0) begin
      errors++; $display("FAIL midrst_zero got busy=%b done=%b st=%b xr=%b d=%0d/%0d",
        busy, done, sys_start, x_ready, sys_data_in_11, sys_data_in_12);
    end
    rst = 1'b1;
    drive_w(1'b0, '0, '0);
    drive_x(1'b0, '0, '0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({done, w_ready, sys_data_in_12} !== {2'b01, 16'd0}) begin
        errors++; $display("FAIL midrst_after_%0d got done=%b wr=%b d12=%0d want 0 1 0",
          i, done, w_ready, sys_data_in_12);
      end
    end
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_stream();
    test_bubble();
    test_back_to_back();
    test_weight_gap();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
